frank_ctrl_sequencer: RTL and testbench
=======================================

// Module: frank_ctrl_sequencer
// PURPOSE
//  Parametrised multi-cycle control sequencer; next generation of the FRANK6000 control unit.
//  Per opcode it steps through up to MAX_CYC cycles, issuing one control word per cycle
//  from a microcode table.
//  Adds the following, which the current unit lacks:
//   - opcode latching
//   - stall handshake with write-enable masking
//   - halt state
//   - optional interrupt entry
//  Drives PC/ADDR/FR/WREG/STATUS muxes and write enables in the datapath.
// PARAMETERS
//  OP_W     4        opcode width (i_opcode)
//  CW_W     16       control word width (o_ctrl)
//  MAX_CYC  4        max cycles per instruction incl. fetch cycle 0; >=2
//  WE_MASK  16'h001F o_ctrl bits that are write enables/state-changing; forced 0 while stalled
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_rst      in   1      reset, asynchronous, active-high
//  i_opcode   in   OP_W   opcode of the instruction at fetch (valid in cycle 0)
//  i_stall    in   1      datapath/memory not ready; hold sequencer this cycle
//  i_halt_req in   1      request halt at next instruction boundary
//  i_irq      in   1      interrupt request (CTRL_IRQ_EN only)
//  o_ctrl     out  CW_W   control word for current cycle
//  o_cycle    out  CYC_W  current cycle index within instruction, CYC_W=$clog2(MAX_CYC)
//  o_fetch    out  1      1 in cycle 0 (instruction fetch/first execute cycle)
//  o_halted   out  1      1 while in HALT
//  o_irq_ack  out  1      1-cycle pulse when interrupt entry issued (CTRL_IRQ_EN only)
// BEHAVIOUR
//  - States: ST_RESET, ST_RUN, ST_HALT, ST_IRQ (ST_IRQ only with CTRL_IRQ_EN).
//  - Reset (async):
//     - state=ST_RESET, r_cyc=0, r_op=0.
//     - Outputs: o_ctrl=0, o_cycle=0, o_fetch=0, o_halted=0, o_irq_ack=0.
//  - ST_RESET: o_ctrl=0; next edge -> ST_RUN, cycle 0. Behaves as a one-cycle dead slot.
//  - ST_RUN cycle 0:
//     - o_ctrl = rom(i_opcode, 0), taken from the live opcode.
//     - r_op <= i_opcode on a non-stalled edge.
//  - ST_RUN cycle k>0: o_ctrl = rom(r_op, k); the latched opcode is used and input changes are ignored.
//  - rom returns {ctrl[CW_W], last}.
//     - last=1 in cycle k ends the instruction; next cycle is 0.
//     - Otherwise k+1.
//  - Runaway guard: cycle MAX_CYC-1 is always treated as last, regardless of the rom flag.
//  - Stall (i_stall=1 in ST_RUN):
//     - State, r_cyc and r_op hold.
//     - o_ctrl = rom(...) & ~WE_MASK, so mux selects stay stable and no writes occur.
//     - Stall has no effect in ST_RESET/ST_HALT (outputs already 0).
//  - Halt: on a non-stalled last cycle with i_halt_req=1 -> ST_HALT.
//     - In ST_HALT: o_ctrl=0, o_halted=1.
//     - i_halt_req=0 -> ST_RUN cycle 0 next edge.
//  - Priority at an instruction boundary: halt > irq > next fetch.
//  - Reset mid-instruction aborts immediately. There is no partial write, since outputs are combinationally 0 in ST_RESET.
//  - o_cycle/o_fetch are derived from the registered state only; o_ctrl is combinational from state and i_opcode.
// CONFIGURATION
//  CTRL_IRQ_EN defined:
//   - On a non-stalled last cycle, if i_irq=1 and no halt request -> ST_IRQ for one cycle.
//   - In ST_IRQ: o_ctrl=`CW_IRQ_ENTRY (call to vector: jump+call bits), o_irq_ack=1.
//   - Then -> ST_RUN cycle 0.
//   - A stall in ST_IRQ holds ST_IRQ with WE bits masked; o_irq_ack is asserted only on the non-stalled cycle.
//  CTRL_IRQ_EN undefined:
//   - i_irq is ignored; o_irq_ack is tied to 0.
//   - ST_IRQ logic is not generated.
// STRUCTURE
//  - Shared header frank_ctrl_pkg.vh holds:
//     - opcode macros (OP_CPYWA..OP_LOOPF)
//     - state encodings ST_*
//     - control-bit field positions (jump, j_mode, call, return, ADDRin, FRin, WREGin, ALUin1/2,
//       PCw, ADDRw, FRw, WREGw, STATUSw)
//     - CW_IRQ_ENTRY and the default WE_MASK
//  - Sub-module frank_ucode_rom #(OP_W,CW_W,MAX_CYC): purely combinational case table,
//    {op,cycle} -> {ctrl,last}. Unlisted entries return ctrl=0, last=1.
//  - The sequencer holds only the state register, cycle counter, opcode latch and masking.
// TESTING
//  1. Reset release, then OP_NOOPR stream -> first cycle ST_RESET with o_ctrl=0.
//     Then o_fetch=1 every cycle, o_cycle=0, o_ctrl=rom(NOOPR,0) (PCw=1).
//  2. OP_CPYRW (2-cycle):
//     - Expect o_cycle 0,1,0.
//     - Cycle 1 o_ctrl=rom(CPYRW,1) even if i_opcode is changed to OP_LOOPF during cycle 1.
//  3. OP_RETRN with i_stall=1 for 3 cycles in cycle 1:
//     - o_cycle holds 1.
//     - o_ctrl[4:0]=0 while stalled; full word on the release cycle; then cycle 0.
//  4. i_halt_req=1 during last cycle of OP_CPYWA:
//     - Next cycle o_halted=1, o_ctrl=0.
//     - Drop req -> following cycle o_fetch=1.
//  5. CTRL_IRQ_EN, i_irq=1 at end of OP_CPYAW:
//     - One ST_IRQ cycle: o_irq_ack=1, o_ctrl=CW_IRQ_ENTRY.
//     - Then o_fetch=1.
//     - With halt_req also 1: halt wins, o_irq_ack stays 0.
//  6. Assert i_rst in cycle 1 of OP_R2_FLR -> o_ctrl=0 in the same cycle; restart via ST_RESET.
//     Also: an opcode whose rom never sets last -> forced back to cycle 0 after cycle MAX_CYC-1.

Source files
------------

// File: rtl/frank_ctrl_sequencer_pkg.sv
// Shared definitions for the FRANK control sequencer: opcodes, states, control-word bit
// positions, IRQ entry word and the default write-enable mask.
package frank_ctrl_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_IRQ   = 2'd3
  } state_t;

  localparam int OP_CPYWA  = 0;
  localparam int OP_CPYAW  = 1;
  localparam int OP_CPYRW  = 2;
  localparam int OP_NOOPR  = 3;
  localparam int OP_RETRN  = 4;
  localparam int OP_R2_FLR = 5;
  localparam int OP_LOOPF  = 6;

  // Write enables occupy the low bits so a single mask can suppress them during stalls
  localparam int CB_PCW     = 0;
  localparam int CB_ADDRW   = 1;
  localparam int CB_FRW     = 2;
  localparam int CB_WREGW   = 3;
  localparam int CB_STATUSW = 4;
  localparam int CB_ADDRIN  = 5;
  localparam int CB_FRIN    = 6;
  localparam int CB_WREGIN  = 7;
  localparam int CB_ALUIN1  = 8;
  localparam int CB_ALUIN2  = 9;
  localparam int CB_JUMP    = 10;
  localparam int CB_J_MODE  = 11;
  localparam int CB_CALL    = 12;
  localparam int CB_RETURN  = 13;

  function automatic logic [15:0] cw_bit(input int pos);
    return 16'd1 << pos;
  endfunction

  localparam logic [15:0] CW_IRQ_ENTRY    = cw_bit(CB_JUMP) | cw_bit(CB_CALL);
  localparam logic [15:0] WE_MASK_DEFAULT = 16'h001F;

endpackage

// File: rtl/frank_ctrl_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction-side inputs and per-cycle control outputs.
interface frank_ctrl_sequencer_if #(
  parameter int OP_W    = 4,
  parameter int CW_W    = 16,
  parameter int MAX_CYC = 4,
  localparam int CYC_W  = $clog2(MAX_CYC)
);
  logic [OP_W-1:0]  i_opcode;
  logic             i_stall;
  logic             i_halt_req;
  logic             i_irq;
  logic [CW_W-1:0]  o_ctrl;
  logic [CYC_W-1:0] o_cycle;
  logic             o_fetch;
  logic             o_halted;
  logic             o_irq_ack;

  modport slave (
    input  i_opcode, i_stall, i_halt_req, i_irq,
    output o_ctrl, o_cycle, o_fetch, o_halted, o_irq_ack
  );

  modport master (
    output i_opcode, i_stall, i_halt_req, i_irq,
    input  o_ctrl, o_cycle, o_fetch, o_halted, o_irq_ack
  );
endinterface

// File: rtl/frank_ucode_rom.sv
// Combinational microcode table: {opcode, cycle} -> {control word, last flag}.
// Unlisted entries return an empty word that ends the instruction.
module frank_ucode_rom
  import frank_ctrl_sequencer_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int CW_W    = 16,
  parameter int MAX_CYC = 4,
  localparam int CYC_W  = $clog2(MAX_CYC)
) (
  input  logic [OP_W-1:0]  op,
  input  logic [CYC_W-1:0] cycle,
  output logic [CW_W:0]    word
);
  logic [15:0] cw;
  logic        last;
  int          op_i;
  int          cyc_i;

  always_comb begin
    cw    = '0;
    last  = 1'b1;
    op_i  = int'(op);
    cyc_i = int'(cycle);
    case (op_i)
      OP_NOOPR: if (cyc_i == 0) cw = cw_bit(CB_PCW);
      OP_CPYWA: case (cyc_i)
        0: begin cw = cw_bit(CB_PCW); last = 1'b0; end
        1: cw = cw_bit(CB_ADDRIN) | cw_bit(CB_ADDRW);
        default: ;
      endcase
      OP_CPYAW: case (cyc_i)
        0: begin cw = cw_bit(CB_PCW); last = 1'b0; end
        1: cw = cw_bit(CB_WREGIN) | cw_bit(CB_WREGW);
        default: ;
      endcase
      OP_CPYRW: case (cyc_i)
        0: begin cw = cw_bit(CB_PCW); last = 1'b0; end
        1: cw = cw_bit(CB_WREGIN) | cw_bit(CB_ALUIN1) | cw_bit(CB_WREGW) | cw_bit(CB_STATUSW);
        default: ;
      endcase
      OP_RETRN: case (cyc_i)
        0: begin cw = cw_bit(CB_ADDRIN) | cw_bit(CB_ADDRW); last = 1'b0; end
        1: cw = cw_bit(CB_RETURN) | cw_bit(CB_JUMP) | cw_bit(CB_PCW);
        default: ;
      endcase
      OP_R2_FLR: case (cyc_i)
        0: begin cw = cw_bit(CB_PCW); last = 1'b0; end
        1: begin cw = cw_bit(CB_FRIN) | cw_bit(CB_ALUIN1) | cw_bit(CB_FRW); last = 1'b0; end
        2: cw = cw_bit(CB_ALUIN2) | cw_bit(CB_STATUSW);
        default: ;
      endcase
      // Never flags last; termination relies on the sequencer's final-cycle guard
      OP_LOOPF: case (cyc_i)
        0: begin cw = cw_bit(CB_PCW); last = 1'b0; end
        1: begin cw = cw_bit(CB_ALUIN1) | cw_bit(CB_FRW); last = 1'b0; end
        2: begin cw = cw_bit(CB_JUMP) | cw_bit(CB_J_MODE); last = 1'b0; end
        3: begin cw = cw_bit(CB_JUMP) | cw_bit(CB_J_MODE) | cw_bit(CB_PCW); last = 1'b0; end
        default: ;
      endcase
      default: ;
    endcase
    word = {CW_W'(cw), last};
  end
endmodule

// File: rtl/frank_ctrl_sequencer.sv
// Multi-cycle control sequencer: state, cycle counter, opcode latch and stall masking.
// Optional interrupt entry is built when CTRL_IRQ_EN is defined.
module frank_ctrl_sequencer
  import frank_ctrl_sequencer_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int CW_W    = 16,
  parameter int MAX_CYC = 4,
  parameter logic [CW_W-1:0] WE_MASK = CW_W'(WE_MASK_DEFAULT)
) (
  input logic                   i_clk,
  input logic                   i_rst,
  frank_ctrl_sequencer_if.slave bus
);
  localparam int CYC_W = $clog2(MAX_CYC);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYC - 1);

  state_t           state_reg, state_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic [OP_W-1:0]  op_reg, op_next;
  logic [OP_W-1:0]  rom_op;
  logic [CW_W:0]    rom_word;
  logic [CW_W-1:0]  rom_ctrl;
  logic             last_eff;
  logic [CW_W-1:0]  ctrl;
  logic             irq_ack;
  logic             halted;

  // Cycle 0 decodes the live opcode; later cycles use the latched copy
  assign rom_op   = (cyc_reg == '0) ? bus.i_opcode : op_reg;
  assign rom_ctrl = rom_word[CW_W:1];
  assign last_eff = rom_word[0] || (cyc_reg == LAST_CYC);

  frank_ucode_rom #(
    .OP_W    (OP_W),
    .CW_W    (CW_W),
    .MAX_CYC (MAX_CYC)
  ) u_rom (
    .op    (rom_op),
    .cycle (cyc_reg),
    .word  (rom_word)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_RESET;
      cyc_reg   <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    op_next    = op_reg;
    ctrl       = '0;
    irq_ack    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      ST_RESET: begin
        state_next = ST_RUN;
        cyc_next   = '0;
      end
      ST_RUN: begin
        ctrl = bus.i_stall ? (rom_ctrl & ~WE_MASK) : rom_ctrl;
        if (!bus.i_stall) begin
          if (cyc_reg == '0) op_next = bus.i_opcode;
          if (last_eff) begin
            cyc_next = '0;
            if (bus.i_halt_req) state_next = ST_HALT;
`ifdef CTRL_IRQ_EN
            else if (bus.i_irq) state_next = ST_IRQ;
`endif
          end else begin
            cyc_next = cyc_reg + 1'b1;
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!bus.i_halt_req) begin
          state_next = ST_RUN;
          cyc_next   = '0;
        end
      end
`ifdef CTRL_IRQ_EN
      ST_IRQ: begin
        ctrl    = bus.i_stall ? (CW_W'(CW_IRQ_ENTRY) & ~WE_MASK) : CW_W'(CW_IRQ_ENTRY);
        irq_ack = !bus.i_stall;
        if (!bus.i_stall) begin
          state_next = ST_RUN;
          cyc_next   = '0;
        end
      end
`endif
      default: state_next = ST_RESET;
    endcase
  end

`ifndef CTRL_IRQ_EN
  logic unused_irq;
  assign unused_irq = bus.i_irq;
`endif

  assign bus.o_ctrl    = ctrl;
  assign bus.o_cycle   = cyc_reg;
  assign bus.o_fetch   = (state_reg == ST_RUN) && (cyc_reg == '0);
  assign bus.o_halted  = halted;
  assign bus.o_irq_ack = irq_ack;
endmodule

// File: tb/tb_frank_ctrl_sequencer.sv
// Directed self-checking bench for frank_ctrl_sequencer; the IRQ step adapts to CTRL_IRQ_EN.
module tb_frank_ctrl_sequencer;
  import frank_ctrl_sequencer_pkg::*;

  logic i_clk;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;

  frank_ctrl_sequencer_if #(.OP_W(4), .CW_W(16), .MAX_CYC(4)) bus ();

  frank_ctrl_sequencer #(.OP_W(4), .CW_W(16), .MAX_CYC(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ctrl, input logic [31:0] cyc,
                            input logic [31:0] fetch, input logic [31:0] halted,
                            input logic [31:0] ack);
    #1;
    check({tag, ".ctrl"},   32'(bus.o_ctrl),    ctrl);
    check({tag, ".cycle"},  32'(bus.o_cycle),   cyc);
    check({tag, ".fetch"},  32'(bus.o_fetch),   fetch);
    check({tag, ".halted"}, 32'(bus.o_halted),  halted);
    check({tag, ".ack"},    32'(bus.o_irq_ack), ack);
    $display("t=%0t %s ctrl=%h cycle=%0d fetch=%b halted=%b ack=%b", $time, tag,
             bus.o_ctrl, bus.o_cycle, bus.o_fetch, bus.o_halted, bus.o_irq_ack);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst          = 1'b1;
    bus.i_opcode   = 4'(OP_NOOPR);
    bus.i_stall    = 1'b0;
    bus.i_halt_req = 1'b0;
    bus.i_irq      = 1'b0;
    tick();
    tick();
    expect_out("reset", 32'h0, 0, 0, 0, 0);

    // NOOPR stream after one dead ST_RESET slot
    i_rst = 1'b0;
    expect_out("dead_slot", 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("noopr", 32'h0001, 0, 1, 0, 0);
    end

    // CPYRW: cycle 1 ignores a live opcode change
    tick();
    bus.i_opcode = 4'(OP_CPYRW);
    expect_out("cpyrw.c0", 32'h0001, 0, 1, 0, 0);
    tick();
    bus.i_opcode = 4'(OP_LOOPF);
    expect_out("cpyrw.c1", 32'h0198, 1, 0, 0, 0);

    // RETRN stalled three cycles in cycle 1
    tick();
    bus.i_opcode = 4'(OP_RETRN);
    expect_out("retrn.c0", 32'h0022, 0, 1, 0, 0);
    tick();
    bus.i_stall  = 1'b1;
    bus.i_opcode = 4'(OP_NOOPR);
    expect_out("retrn.stall1", 32'h2400, 1, 0, 0, 0);
    tick();
    expect_out("retrn.stall2", 32'h2400, 1, 0, 0, 0);
    tick();
    expect_out("retrn.stall3", 32'h2400, 1, 0, 0, 0);
    tick();
    bus.i_stall = 1'b0;
    expect_out("retrn.release", 32'h2401, 1, 0, 0, 0);

    // CPYWA with halt requested in its last cycle
    tick();
    bus.i_opcode = 4'(OP_CPYWA);
    expect_out("cpywa.c0", 32'h0001, 0, 1, 0, 0);
    tick();
    bus.i_halt_req = 1'b1;
    expect_out("cpywa.c1", 32'h0022, 1, 0, 0, 0);
    tick();
    expect_out("halt1", 32'h0, 0, 0, 1, 0);
    tick();
    bus.i_halt_req = 1'b0;
    bus.i_opcode   = 4'(OP_CPYAW);
    expect_out("halt2", 32'h0, 0, 0, 1, 0);

    // CPYAW with interrupt at its end
    tick();
    expect_out("cpyaw.c0", 32'h0001, 0, 1, 0, 0);
    tick();
    bus.i_irq = 1'b1;
    expect_out("cpyaw.c1", 32'h0088, 1, 0, 0, 0);
    tick();
`ifdef CTRL_IRQ_EN
    bus.i_irq = 1'b0;
    expect_out("irq_entry", 32'(CW_IRQ_ENTRY), 0, 0, 0, 1);
    tick();
`endif
    bus.i_irq = 1'b0;
    expect_out("after_irq", 32'h0001, 0, 1, 0, 0);

    // Halt outranks irq at the boundary
    tick();
    bus.i_irq      = 1'b1;
    bus.i_halt_req = 1'b1;
    expect_out("prio.c1", 32'h0088, 1, 0, 0, 0);
    tick();
    bus.i_irq      = 1'b0;
    bus.i_halt_req = 1'b0;
    bus.i_opcode   = 4'(OP_R2_FLR);
    expect_out("prio.halt", 32'h0, 0, 0, 1, 0);

    // Reset mid-instruction in R2_FLR cycle 1
    tick();
    expect_out("r2flr.c0", 32'h0001, 0, 1, 0, 0);
    tick();
    expect_out("r2flr.c1", 32'h0144, 1, 0, 0, 0);
    i_rst = 1'b1;
    expect_out("r2flr.abort", 32'h0, 0, 0, 0, 0);
    tick();
    i_rst        = 1'b0;
    bus.i_opcode = 4'(OP_LOOPF);
    expect_out("restart.dead", 32'h0, 0, 0, 0, 0);

    // LOOPF never flags last; guard ends it after cycle 3
    tick();
    expect_out("loopf.c0", 32'h0001, 0, 1, 0, 0);
    tick();
    expect_out("loopf.c1", 32'h0104, 1, 0, 0, 0);
    tick();
    expect_out("loopf.c2", 32'h0C00, 2, 0, 0, 0);
    tick();
    bus.i_opcode = 4'(OP_NOOPR);
    expect_out("loopf.c3", 32'h0C01, 3, 0, 0, 0);
    tick();
    expect_out("loopf.wrap", 32'h0001, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
